// File: rtl/srio_dma_split_seg.sv
// Strips the header beat from each AXIS frame and re-emits the payload as
// segments of at most L beats, each tagged with a destination TUSER.
module srio_dma_split_seg #(
  parameter int DATA_W    = 64,
  parameter int TUSER_W   = 32,
  parameter int MAX_WORDS = 32
) (
  input  logic               AXIS_ACLK,
  input  logic               AXIS_ARESETN,
  input  logic [DATA_W-1:0]  S_AXIS_TDATA,
  input  logic               S_AXIS_TVALID,
  input  logic               S_AXIS_TLAST,
  output logic               S_AXIS_TREADY,
  output logic [DATA_W-1:0]  M_AXIS_TDATA,
  output logic               M_AXIS_TVALID,
  output logic               M_AXIS_TLAST,
  output logic [TUSER_W-1:0] M_AXIS_TUSER,
  input  logic               M_AXIS_TREADY,
  input  logic [31:0]        cmd,
  input  logic [31:0]        num_pkts,
  output logic [31:0]        status,
  output logic [TUSER_W-1:0] tuser_last
);
  localparam int LW  = $clog2(MAX_WORDS + 1);
  localparam int BPB = DATA_W / 8;

  typedef enum logic [1:0] {HDR, PAYLOAD, DONE} state_t;
  state_t state, state_n;

  logic               en, srst, auto_c;
  logic [LW-1:0]      cmd_len, seg_l, beat_cnt, cnt_inc;
  logic [TUSER_W-1:0] tuser_r;
  logic [31:0]        seg_cnt;
  logic               hdr_err;
  logic               s_acc, m_acc, len_hit, last_pend;
  logic               unused_ok;

  assign en        = cmd[0];
  assign srst      = cmd[1];
  assign auto_c    = cmd[2];
  assign unused_ok = ^{cmd[31:16], cmd[7:3]};

  always_comb begin
    cmd_len = LW'(cmd[15:8]);
    if (cmd[15:8] == 8'd0 || {24'd0, cmd[15:8]} > 32'(MAX_WORDS))
      cmd_len = LW'(MAX_WORDS);
  end

  assign cnt_inc = beat_cnt + LW'(1);
  assign len_hit = (cnt_inc == seg_l);
  // Final TLAST of a limited run is sitting in the output register: take
  // nothing more so DONE is entered with an empty pipe.
  assign last_pend = M_AXIS_TVALID && M_AXIS_TLAST && (num_pkts != 32'd0) &&
                     (seg_cnt + 32'd1 == num_pkts);

  assign S_AXIS_TREADY = en && !srst && !last_pend &&
                         (state == HDR ||
                          (state == PAYLOAD && (!M_AXIS_TVALID || M_AXIS_TREADY)));
  assign s_acc = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_acc = M_AXIS_TVALID && M_AXIS_TREADY;

  always_comb begin
    state_n = state;
    case (state)
      HDR:     if (s_acc && !S_AXIS_TLAST) state_n = PAYLOAD;
      PAYLOAD: if (s_acc && (S_AXIS_TLAST || (len_hit && !auto_c))) state_n = HDR;
      default: ;
    endcase
    if (m_acc && last_pend) state_n = DONE;
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN)  state <= HDR;
    else if (srst)      state <= HDR;
    else                state <= state_n;
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TUSER  <= '0;
      tuser_r       <= '0;
      tuser_last    <= '0;
      seg_l         <= '0;
      beat_cnt      <= '0;
      seg_cnt       <= '0;
      hdr_err       <= 1'b0;
    end else if (srst) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TUSER  <= '0;
      tuser_r       <= '0;
      tuser_last    <= '0;
      seg_l         <= '0;
      beat_cnt      <= '0;
      seg_cnt       <= '0;
      hdr_err       <= 1'b0;
    end else begin
      if (m_acc) begin
        M_AXIS_TVALID <= 1'b0;
        if (M_AXIS_TLAST) begin
          seg_cnt    <= seg_cnt + 32'd1;
          tuser_last <= M_AXIS_TUSER;
        end
      end
      if (s_acc && state == HDR) begin
        if (S_AXIS_TLAST) hdr_err <= 1'b1;
        else begin
          tuser_r  <= S_AXIS_TDATA[TUSER_W-1:0];
          beat_cnt <= '0;
          seg_l    <= cmd_len;
        end
      end
      if (s_acc && state == PAYLOAD) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= S_AXIS_TDATA;
        M_AXIS_TLAST  <= S_AXIS_TLAST || len_hit;
        M_AXIS_TUSER  <= tuser_r;
        // Length-closed segment: advance the address by the bytes just sent.
        if (!S_AXIS_TLAST && len_hit) begin
          beat_cnt <= '0;
          seg_l    <= cmd_len;
          tuser_r  <= tuser_r + TUSER_W'(32'(seg_l) * 32'(BPB));
        end else begin
          beat_cnt <= cnt_inc;
        end
      end
    end
  end

  assign status = {seg_cnt[15:0], 13'd0, hdr_err,
                   (state == PAYLOAD) || M_AXIS_TVALID, state == DONE};
endmodule
